// File: rtl/ethernet_tx_arbiter.sv
// ethernet_tx_arbiter: round-robin, packet-atomic sharing of the ethernet_sender TX buffer write port.
// Optional ETH_TX_ARB_STATS_EN adds per-source sent counters and a drop counter.
module ethernet_tx_arbiter #(
    parameter int num_req_p    = 2,
    parameter int data_width_p = 64,
    parameter int eth_mtu_p    = 2048,
    localparam int bytes_lp             = data_width_p / 8,
    localparam int addr_width_lp        = $clog2(eth_mtu_p),
    localparam int packet_size_width_lp = $clog2(eth_mtu_p + 1),
    localparam int nb_width_lp          = $clog2(bytes_lp + 1),
    localparam int lg_bytes_lp          = (bytes_lp == 1) ? 1 : $clog2(bytes_lp),
    localparam int size_width_lp        = $clog2(lg_bytes_lp + 1),
    localparam int id_width_lp          = $clog2(num_req_p)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [num_req_p-1:0]              req_v_i,
    input  logic [num_req_p*data_width_p-1:0] req_data_i,
    input  logic [num_req_p-1:0]              req_last_i,
    input  logic [num_req_p*nb_width_lp-1:0]  req_bytes_i,
    output logic [num_req_p-1:0]              req_yumi_o,
    input  logic                              packet_req_i,
    output logic                              packet_wvalid_o,
    output logic [addr_width_lp-1:0]          packet_waddr_o,
    output logic [data_width_p-1:0]           packet_wdata_o,
    output logic [size_width_lp-1:0]          packet_wdata_size_o,
    output logic                              packet_wsize_valid_o,
    output logic [packet_size_width_lp-1:0]   packet_wsize_o,
    output logic                              packet_send_o,
    output logic                              grant_v_o,
    output logic [id_width_lp-1:0]            grant_id_o,
`ifdef ETH_TX_ARB_STATS_EN
    output logic [num_req_p*16-1:0]           sent_count_o,
    output logic [15:0]                       drop_count_o,
`endif
    output logic                              drop_o
);

    typedef enum logic [2:0] {IDLE, DATA, SIZE, SEND, DROP} state_e;

    localparam int cw_lp = packet_size_width_lp + 1;
    localparam logic [cw_lp-1:0] mtu_lp  = cw_lp'(eth_mtu_p);
    localparam logic [cw_lp-1:0] full_lp = cw_lp'(bytes_lp);

    state_e                          state_r, state_n;
    logic [id_width_lp-1:0]          ptr_r, grant_r, win, ptr_n;
    logic [packet_size_width_lp-1:0] cnt_r, cnt_n;
    logic [cw_lp-1:0]                sum;
    logic [nb_width_lp-1:0]          nb;
    logic                            ovf_r, v, last, fits;

    // Lowest requester overall, overridden by the lowest requester at or after the pointer.
    always_comb begin
        win = ptr_r;
        for (int j = num_req_p - 1; j >= 0; j--)
            if (req_v_i[j]) win = id_width_lp'(j);
        for (int j = num_req_p - 1; j >= 0; j--)
            if (req_v_i[j] && j >= int'(ptr_r)) win = id_width_lp'(j);
    end

    assign v     = req_v_i[grant_r];
    assign last  = req_last_i[grant_r];
    assign nb    = last ? req_bytes_i[int'(grant_r)*nb_width_lp +: nb_width_lp] : nb_width_lp'(bytes_lp);
    assign fits  = !ovf_r && ({1'b0, cnt_r} + full_lp <= mtu_lp);
    assign sum   = {1'b0, cnt_r} + cw_lp'(nb);
    assign cnt_n = (sum > mtu_lp) ? packet_size_width_lp'(mtu_lp + 1'b1) : packet_size_width_lp'(sum);
    assign ptr_n = (int'(grant_r) == num_req_p - 1) ? '0 : grant_r + 1'b1;

    assign grant_v_o           = state_r != IDLE;
    assign grant_id_o          = grant_r;
    assign packet_waddr_o      = cnt_r[addr_width_lp-1:0];
    assign packet_wdata_o      = req_data_i[int'(grant_r)*data_width_p +: data_width_p];
    assign packet_wdata_size_o = size_width_lp'($clog2(bytes_lp));
    assign packet_wsize_o      = cnt_r;

    always_comb begin
        state_n              = state_r;
        req_yumi_o           = '0;
        packet_wvalid_o      = 1'b0;
        packet_wsize_valid_o = state_r == SIZE;
        packet_send_o        = state_r == SEND;
        drop_o               = state_r == DROP;
        case (state_r)
            IDLE: state_n = (packet_req_i && |req_v_i) ? DATA : IDLE;
            DATA: begin
                req_yumi_o[grant_r] = v;
                packet_wvalid_o     = v && fits;
                if (v && last) state_n = fits ? SIZE : DROP;
            end
            SIZE:    state_n = SEND;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            ptr_r   <= '0;
            grant_r <= '0;
            cnt_r   <= '0;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            if (state_r == IDLE && state_n == DATA) begin
                grant_r <= win;
                cnt_r   <= '0;
                ovf_r   <= 1'b0;
            end
            // Overflow is sticky: later words of an oversize packet are drained, never written.
            if (state_r == DATA && v) begin
                cnt_r <= cnt_n;
                ovf_r <= !fits;
            end
            if (state_r == SEND || state_r == DROP) ptr_r <= ptr_n;
        end
    end

`ifdef ETH_TX_ARB_STATS_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sent_count_o <= '0;
            drop_count_o <= '0;
        end else begin
            if (state_r == SEND)
                sent_count_o[int'(grant_r)*16 +: 16] <= sent_count_o[int'(grant_r)*16 +: 16] + 16'd1;
            if (state_r == DROP) drop_count_o <= drop_count_o + 16'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (data_width_p == 32 || data_width_p == 64)
                else $error("data_width_p must be 32 or 64");
            if (state_r == DATA && v && last)
                assert (nb != '0 && int'(nb) <= bytes_lp) else $error("req_bytes_i out of range on last word");
            if (packet_wvalid_o)
                assert (int'(packet_waddr_o) + bytes_lp <= eth_mtu_p) else $error("write beyond eth_mtu_p");
            if (packet_wvalid_o || packet_wsize_valid_o || packet_send_o)
                assert (packet_req_i) else $error("packet_req_i low while writing to the sender");
        end
    end
`endif

endmodule
